si571_pll_sequencer: RTL and testbench

Supervisory controller for the Si571 flip-flop PLL on the Red Pitaya converter board.
- Drives the PLL's configuration enable.
- Qualifies reference presence and lock.
- Detects loss of lock and retries with backoff.
- Escalates to a latched fault after repeated failures.
- Sits between the register/control interface and the PLL block, in the clk_i (125 MHz system) domain.

---
 rtl/si571_seq_pkg.sv | 27 ++
 rtl/bit_sync_2ff.sv | 21 ++
 rtl/si571_pll_sequencer.sv | 154 +++++++++++++++
 tb/tb_si571_pll_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/si571_seq_pkg.sv
// rtl/si571_seq_pkg.sv - shared state encoding and default timing for the Si571 PLL sequencer
package si571_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REF = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_CONFIRM  = 3'd3,
        ST_LOCKED   = 3'd4,
        ST_BACKOFF  = 3'd5,
        ST_FAULT    = 3'd6
    } seq_state_t;

    localparam int RETRY_W = 3;

    // Defaults assume the 125 MHz system clock: 10 ms settle, 100 ms timeout.
    localparam int SYS_CLK_HZ         = 125_000_000;
    localparam int DEF_SETTLE_CYCLES  = SYS_CLK_HZ / 100;
    localparam int DEF_CONFIRM_CYCLES = 4096;
    localparam int DEF_TIMEOUT_CYCLES = SYS_CLK_HZ / 10;
    localparam int DEF_MAX_RETRY      = 4;

    function automatic logic state_drives_cfg_en(input seq_state_t s);
        return (s == ST_SETTLE) || (s == ST_CONFIRM) || (s == ST_LOCKED);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - single-bit two-flop synchroniser with asynchronous active-high reset
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/si571_pll_sequencer.sv
// rtl/si571_pll_sequencer.sv - Si571 PLL enable, lock qualification, retry/backoff and fault supervisor
module si571_pll_sequencer
    import si571_seq_pkg::*;
#(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
    parameter int unsigned LOSS_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              ref_val_i,
    input  logic              pll_ok_i,
    output logic              pll_cfg_en_o,
    output logic              locked_o,
    output logic              fault_o,
    output logic [2:0]        state_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [LOSS_W-1:0] lock_loss_cnt_o
);

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic ref_s;
    logic ok_s;

    bit_sync_2ff u_sync_ref (
        .clk (clk_i),
        .rst (rst_i),
        .d   (ref_val_i),
        .q   (ref_s)
    );

    bit_sync_2ff u_sync_ok (
        .clk (clk_i),
        .rst (rst_i),
        .d   (pll_ok_i),
        .q   (ok_s)
    );

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   run_q;
    logic [RETRY_W-1:0] retry_q;
    logic [LOSS_W-1:0]  lock_loss_q;
    logic               good_sample;
    logic               state_change;
    logic               lock_lost;

    always_comb begin
        good_sample = 1'b0;
        case (state_q)
            ST_WAIT_REF: good_sample = ref_s;
            ST_CONFIRM:  good_sample = ref_s & ok_s;
            default:     good_sample = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (clear_i && (state_q == ST_FAULT)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_REF;
                ST_WAIT_REF: begin
                    if (good_sample && (run_q == CONFIRM_LAST)) state_d = ST_SETTLE;
                    else if (timer_q == TIMEOUT_LAST)           state_d = ST_BACKOFF;
                end
                ST_SETTLE: begin
                    if (timer_q == SETTLE_LAST) state_d = ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    if (good_sample && (run_q == CONFIRM_LAST)) state_d = ST_LOCKED;
                    else if (timer_q == TIMEOUT_LAST)           state_d = ST_BACKOFF;
                end
                ST_LOCKED: begin
                    if (!(ok_s && ref_s)) state_d = ST_BACKOFF;
                end
                // retry_q already holds the count incremented on entry
                ST_BACKOFF: begin
                    if (retry_q >= RETRY_LIMIT)      state_d = ST_FAULT;
                    else if (timer_q == SETTLE_LAST) state_d = ST_WAIT_REF;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign state_change = (state_d != state_q);
    assign lock_lost    = (state_q == ST_LOCKED) && (state_d == ST_BACKOFF);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_change)      timer_q <= '0;
            else if (timer_q != '1) timer_q <= timer_q + CNT_W'(1);
            if (state_change || !good_sample) run_q <= '0;
            else                              run_q <= run_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q     <= '0;
            lock_loss_q <= '0;
        end else begin
            if (clear_i) begin
                retry_q     <= '0;
                lock_loss_q <= '0;
            end else begin
                if (state_change && ((state_d == ST_IDLE) || (state_d == ST_LOCKED)))
                    retry_q <= '0;
                else if (state_change && (state_d == ST_BACKOFF) && (retry_q != '1))
                    retry_q <= retry_q + RETRY_W'(1);
                if (lock_lost && (lock_loss_q != '1))
                    lock_loss_q <= lock_loss_q + LOSS_W'(1);
            end
        end
    end

    // Status outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pll_cfg_en_o <= 1'b0;
            locked_o     <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            pll_cfg_en_o <= state_drives_cfg_en(state_d);
            locked_o     <= (state_d == ST_LOCKED);
            fault_o      <= (state_d == ST_FAULT);
        end
    end

    assign state_o         = state_q;
    assign retry_cnt_o     = retry_q;
    assign lock_loss_cnt_o = lock_loss_q;

endmodule

// File: tb/tb_si571_pll_sequencer.sv
// tb/tb_si571_pll_sequencer.sv - directed self-checking bench for si571_pll_sequencer
module tb_si571_pll_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        ref_val = 1'b0;
    logic        pll_ok = 1'b0;
    logic        cfg_en;
    logic        locked;
    logic        fault;
    logic [2:0]  state;
    logic [2:0]  retry_cnt;
    logic [15:0] lock_loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    si571_pll_sequencer #(
        .CNT_W          (24),
        .SETTLE_CYCLES  (16),
        .CONFIRM_CYCLES (8),
        .TIMEOUT_CYCLES (64),
        .MAX_RETRY      (3),
        .LOSS_W         (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .clear_i         (clear),
        .ref_val_i       (ref_val),
        .pll_ok_i        (pll_ok),
        .pll_cfg_en_o    (cfg_en),
        .locked_o        (locked),
        .fault_o         (fault),
        .state_o         (state),
        .retry_cnt_o     (retry_cnt),
        .lock_loss_cnt_o (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
        int n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    int  k;
    bit  saw_locked;

    initial begin
        // reset values
        #3;
        check("rst_state", 32'(state), 0);
        check("rst_cfg_en", 32'(cfg_en), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_retry", 32'(retry_cnt), 0);
        check("rst_loss", 32'(lock_loss_cnt), 0);
        #20 rst = 1'b0;
        tick(2);
        check("idle_hold", 32'(state), 0);

        // nominal lock
        ref_val = 1'b1; pll_ok = 1'b1; enable = 1'b1;
        tick();
        check("nom_wait_ref", 32'(state), 1);
        check("nom_wait_cfg", 32'(cfg_en), 0);
        tick(8);
        check("nom_still_wait", 32'(state), 1);
        tick();
        check("nom_settle", 32'(state), 2);
        check("nom_settle_cfg", 32'(cfg_en), 1);
        tick(15);
        check("nom_settle_end", 32'(state), 2);
        tick();
        check("nom_confirm", 32'(state), 3);
        tick(7);
        check("nom_confirm_end", 32'(locked), 0);
        tick();
        check("nom_locked_state", 32'(state), 4);
        check("nom_locked", 32'(locked), 1);
        check("nom_retry", 32'(retry_cnt), 0);
        check("nom_cfg_en", 32'(cfg_en), 1);

        // single-cycle lock loss
        pll_ok = 1'b0;
        tick();
        pll_ok = 1'b1;
        tick();
        check("loss_sync_delay", 32'(state), 4);
        tick();
        check("loss_backoff", 32'(state), 5);
        check("loss_cfg_en", 32'(cfg_en), 0);
        check("loss_cnt", 32'(lock_loss_cnt), 1);
        check("loss_retry", 32'(retry_cnt), 1);
        tick(15);
        check("loss_backoff_end", 32'(state), 5);
        tick();
        check("loss_wait_ref", 32'(state), 1);
        wait_state("loss_relock", 3'd4, 100);
        check("relock_retry", 32'(retry_cnt), 0);
        check("relock_loss", 32'(lock_loss_cnt), 1);

        // no reference: timeouts escalate to fault
        enable = 1'b0; ref_val = 1'b0;
        tick();
        check("dis_idle", 32'(state), 0);
        check("dis_cfg_en", 32'(cfg_en), 0);
        check("dis_loss_kept", 32'(lock_loss_cnt), 1);
        tick(3);
        enable = 1'b1;
        tick();
        check("noref_wait_ref", 32'(state), 1);
        for (int i = 1; i <= 3; i++) begin
            tick(63);
            check("noref_before_to", 32'(state), 1);
            tick();
            check("noref_timeout", 32'(state), 5);
            check("noref_retry", 32'(retry_cnt), 32'(i));
            if (i < 3) begin
                tick(15);
                check("noref_backoff", 32'(state), 5);
                tick();
                check("noref_rewait", 32'(state), 1);
            end
        end
        tick();
        check("fault_state", 32'(state), 6);
        check("fault_flag", 32'(fault), 1);
        check("fault_cfg_en", 32'(cfg_en), 0);
        check("fault_retry", 32'(retry_cnt), 3);

        // fault exit via clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_idle", 32'(state), 0);
        check("clr_fault", 32'(fault), 0);
        check("clr_retry", 32'(retry_cnt), 0);
        check("clr_loss", 32'(lock_loss_cnt), 0);
        tick();
        check("clr_wait_ref", 32'(state), 1);

        // lock, lose reference, fault, exit via enable low
        ref_val = 1'b1; pll_ok = 1'b1;
        wait_state("lock2", 3'd4, 100);
        ref_val = 1'b0;
        wait_state("fault2", 3'd6, 400);
        check("fault2_loss", 32'(lock_loss_cnt), 1);
        check("fault2_retry", 32'(retry_cnt), 3);
        enable = 1'b0;
        tick();
        check("en_exit_idle", 32'(state), 0);
        check("en_exit_fault", 32'(fault), 0);
        check("en_exit_loss", 32'(lock_loss_cnt), 1);
        check("en_exit_retry", 32'(retry_cnt), 0);

        // periodic bad sample during CONFIRM
        ref_val = 1'b1; pll_ok = 1'b1;
        tick(3);
        enable = 1'b1;
        wait_state("bad_confirm", 3'd3, 100);
        saw_locked = 1'b0;
        for (k = 0; k < 64; k++) begin
            pll_ok = (k % 6 != 0);
            tick();
            if (state == 3'd4) saw_locked = 1'b1;
            if (k == 62) check("bad_confirm_hold", 32'(state), 3);
        end
        check("bad_never_locked", 32'(saw_locked), 0);
        check("bad_timeout", 32'(state), 5);
        check("bad_retry", 32'(retry_cnt), 1);
        pll_ok = 1'b1;
        wait_state("bad_relock", 3'd4, 200);

        // clear overrides a same-cycle lock-loss increment
        pll_ok = 1'b0;
        tick();
        pll_ok = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_backoff", 32'(state), 5);
        check("ovr_loss", 32'(lock_loss_cnt), 0);
        check("ovr_retry", 32'(retry_cnt), 0);
        wait_state("ovr_relock", 3'd4, 200);
        pll_ok = 1'b0;
        tick();
        pll_ok = 1'b1;
        tick(2);
        check("loss2_cnt", 32'(lock_loss_cnt), 1);
        wait_state("pre_rst_lock", 3'd4, 200);
        check("pre_rst_cfg", 32'(cfg_en), 1);

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        check("arst_cfg_en", 32'(cfg_en), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_state", 32'(state), 0);
        check("arst_retry", 32'(retry_cnt), 0);
        check("arst_loss", 32'(lock_loss_cnt), 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_wait_ref", 32'(state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
